// File: rtl/ps2_command_decoder_if.sv
// PS/2 command decoder bus: raw PS/2 pins in, game commands and debug bytes out.
//   ps2_clk, ps2_dat   : raw asynchronous PS/2 lines (keyboard -> decoder)
//   p1_dir, p2_dir     : registered player directions (UP=00 RIGHT=01 DOWN=10 LEFT=11)
//   start_pulse        : one-cycle pulse on a fresh space make
//   reset_req_pulse    : one-cycle pulse on every Esc make
//   scan_code/valid    : last accepted byte and its one-cycle update strobe
//   frame_err          : one-cycle pulse on a rejected or timed-out frame
// master = keyboard/consumer side, slave = decoder side.
interface ps2_command_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       start_pulse;
  logic       reset_req_pulse;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  p1_dir, p2_dir, start_pulse, reset_req_pulse, scan_code, scan_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output p1_dir, p2_dir, start_pulse, reset_req_pulse, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_command_decoder.sv
// Lightbike input front end: synchronises and filters the PS/2 lines, deserialises
// 11-bit frames, tracks E0/F0 prefixes and turns key makes into game commands.
//   board_clk : system clock (only clock)
//   reset     : synchronous, active-high
//   bus       : ps2_command_decoder_if.slave (PS/2 pins in, command outputs)
module ps2_command_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  board_clk,
  input  logic                  reset,
  ps2_command_decoder_if.slave  bus
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_ESC   = 8'h76;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state, state_nx;
  logic                clk_s1, clk_s2, dat_s1, dat_s2;
  logic                filt_clk, fall;
  logic [FCNT_W-1:0]   filt_cnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shift_reg;
  logic                parity_ok;
  logic [7:0]          scan_code;
  logic                scan_valid, frame_err;
  logic                ext, brk, space_held;
  logic [1:0]          p1_dir, p2_dir;
  logic                start_pulse, reset_req_pulse;

  logic                timeout_c, begin_c, shift_c, par_c, accept_c, err_c;
  logic [1:0]          p1_req_c, p2_req_c;
  logic                p1_vld_c, p2_vld_c, space_c, esc_c;

  // Two-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge board_clk) begin
    if (reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk; clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat; dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level follows the synchronised clock only after FILTER_LEN
  // consecutive differing samples; a 1->0 flip raises fall for one cycle.
  always_ff @(posedge board_clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        fall     <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Mid-frame watchdog; cleared on every fall and while idle
  assign timeout_c = (state != IDLE) && !fall && (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge board_clk) begin
    if (reset || state == IDLE || fall || timeout_c) tcnt <= '0;
    else                                             tcnt <= tcnt + 1'b1;
  end

  // Frame FSM: state register
  always_ff @(posedge board_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Frame FSM: next state, advancing only on fall events
  always_comb begin
    state_nx = state;
    if (timeout_c) begin
      state_nx = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Frame FSM: datapath strobes
  always_comb begin
    begin_c  = 1'b0;
    shift_c  = 1'b0;
    par_c    = 1'b0;
    accept_c = 1'b0;
    err_c    = timeout_c;
    if (fall) begin
      case (state)
        IDLE:    begin_c = !dat_s2;
        DATA:    shift_c = 1'b1;
        PARITY:  par_c   = 1'b1;
        STOP:    if (dat_s2 && parity_ok) accept_c = 1'b1;
                 else                     err_c    = 1'b1;
        default: ;
      endcase
    end
  end

  // Deserialiser and byte output; rejected frames leave scan_code untouched
  always_ff @(posedge board_clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_ok  <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= accept_c;
      frame_err  <= err_c;
      if (begin_c) bit_cnt <= '0;
      if (shift_c) begin
        shift_reg <= {dat_s2, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_c)    parity_ok <= ^{shift_reg, dat_s2};
      if (accept_c) scan_code <= shift_reg;
    end
  end

  // Key-to-command lookup under the current prefix flags
  always_comb begin
    p1_req_c = DIR_UP;
    p2_req_c = DIR_UP;
    p1_vld_c = 1'b0;
    p2_vld_c = 1'b0;
    space_c  = 1'b0;
    esc_c    = 1'b0;
    if (!brk && !ext) begin
      case (scan_code)
        8'h1D:   begin p1_req_c = DIR_UP;    p1_vld_c = 1'b1; end
        8'h1B:   begin p1_req_c = DIR_DOWN;  p1_vld_c = 1'b1; end
        8'h1C:   begin p1_req_c = DIR_LEFT;  p1_vld_c = 1'b1; end
        8'h23:   begin p1_req_c = DIR_RIGHT; p1_vld_c = 1'b1; end
        K_SPACE: space_c = 1'b1;
        K_ESC:   esc_c   = 1'b1;
        default: ;
      endcase
    end else if (!brk && ext) begin
      case (scan_code)
        8'h75:   begin p2_req_c = DIR_UP;    p2_vld_c = 1'b1; end
        8'h72:   begin p2_req_c = DIR_DOWN;  p2_vld_c = 1'b1; end
        8'h6B:   begin p2_req_c = DIR_LEFT;  p2_vld_c = 1'b1; end
        8'h74:   begin p2_req_c = DIR_RIGHT; p2_vld_c = 1'b1; end
        default: ;
      endcase
    end
  end

  // Command state; the reverse of a direction is that direction with bit 1 flipped
  always_ff @(posedge board_clk) begin
    if (reset) begin
      ext             <= 1'b0;
      brk             <= 1'b0;
      space_held      <= 1'b0;
      p1_dir          <= DIR_RIGHT;
      p2_dir          <= DIR_LEFT;
      start_pulse     <= 1'b0;
      reset_req_pulse <= 1'b0;
    end else begin
      start_pulse     <= 1'b0;
      reset_req_pulse <= 1'b0;
      if (scan_valid) begin
        if (scan_code == K_EXT) begin
          ext <= 1'b1;
        end else if (scan_code == K_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk && scan_code == K_SPACE) space_held <= 1'b0;
          if (p1_vld_c && p1_req_c != (p1_dir ^ 2'b10)) p1_dir <= p1_req_c;
          if (p2_vld_c && p2_req_c != (p2_dir ^ 2'b10)) p2_dir <= p2_req_c;
          if (space_c) begin
            start_pulse <= !space_held;
            space_held  <= 1'b1;
          end
          reset_req_pulse <= esc_c;
        end
      end
    end
  end

  assign bus.p1_dir          = p1_dir;
  assign bus.p2_dir          = p2_dir;
  assign bus.start_pulse     = start_pulse;
  assign bus.reset_req_pulse = reset_req_pulse;
  assign bus.scan_code       = scan_code;
  assign bus.scan_valid      = scan_valid;
  assign bus.frame_err       = frame_err;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Directed bench for ps2_command_decoder: drives PS/2 frames bit by bit and
// checks decoded bytes, direction updates, pulses and error handling.
module tb_ps2_command_decoder;

  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned HALF    = 20;

  logic board_clk = 1'b0;
  logic reset     = 1'b1;

  ps2_command_decoder_if bus();

  ps2_command_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 board_clk = ~board_clk;

  int checks = 0;
  int errs   = 0;
  int cyc = 0, sv_cnt = 0, st_cnt = 0, rr_cnt = 0, fe_cnt = 0;
  int sv_cyc = -100, p1_chg_cyc = -100;
  logic [1:0] prev_p1 = 2'b01;

  // Pulse counters and change timestamps, sampled away from the active edge
  always @(negedge board_clk) begin
    cyc++;
    if (bus.scan_valid === 1'b1)      begin sv_cnt++; sv_cyc = cyc; end
    if (bus.start_pulse === 1'b1)     st_cnt++;
    if (bus.reset_req_pulse === 1'b1) rr_cnt++;
    if (bus.frame_err === 1'b1)       fe_cnt++;
    if (bus.p1_dir !== prev_p1) begin p1_chg_cyc = cyc; prev_p1 = bus.p1_dir; end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge board_clk);
    #1;
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Sends the first n bits of a frame; optional 3-cycle clock glitch in each high phase
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      bus.ps2_dat = f[i];
      if (glitch) begin
        wait_cyc(12);
        bus.ps2_clk = 1'b0;
        wait_cyc(3);
        bus.ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(build_frame(d, 1'b0, 1'b0), 11, 1'b0);
    bus.ps2_dat = 1'b1;
    wait_cyc(30);
  endtask

  task automatic pulse_reset();
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    checks++; if (bus.p1_dir !== 2'b01) begin errs++; $display("FAIL reset_p1_dir: got %b expected 01", bus.p1_dir); end
    checks++; if (bus.p2_dir !== 2'b11) begin errs++; $display("FAIL reset_p2_dir: got %b expected 11", bus.p2_dir); end
    checks++; if (bus.scan_code !== 8'h00) begin errs++; $display("FAIL reset_scan_code: got %h expected 00", bus.scan_code); end
    checks++; if ({bus.scan_valid, bus.start_pulse, bus.reset_req_pulse, bus.frame_err} !== 4'b0000) begin
      errs++; $display("FAIL reset_pulses: got %b expected 0000", {bus.scan_valid, bus.start_pulse, bus.reset_req_pulse, bus.frame_err});
    end
  endtask

  task automatic test_basic();
    int sv0 = sv_cnt, fe0 = fe_cnt;
    send_byte(8'h1D);
    checks++; if (bus.scan_code !== 8'h1D) begin errs++; $display("FAIL basic_scan_code: got %h expected 1d", bus.scan_code); end
    checks++; if (sv_cnt - sv0 !== 1) begin errs++; $display("FAIL basic_scan_valid_cycles: got %0d expected 1", sv_cnt - sv0); end
    checks++; if (bus.p1_dir !== 2'b00) begin errs++; $display("FAIL basic_p1_dir: got %b expected 00", bus.p1_dir); end
    checks++; if (p1_chg_cyc !== sv_cyc + 1) begin errs++; $display("FAIL basic_dir_latency: got %0d expected %0d", p1_chg_cyc - sv_cyc, 1); end
    checks++; if (fe_cnt !== fe0) begin errs++; $display("FAIL basic_frame_err: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_reverse();
    pulse_reset();
    send_byte(8'h1C);
    checks++; if (bus.p1_dir !== 2'b01) begin errs++; $display("FAIL reverse_reject: got %b expected 01", bus.p1_dir); end
    send_byte(8'h1D);
    checks++; if (bus.p1_dir !== 2'b00) begin errs++; $display("FAIL reverse_up: got %b expected 00", bus.p1_dir); end
    send_byte(8'h1C);
    checks++; if (bus.p1_dir !== 2'b11) begin errs++; $display("FAIL reverse_left: got %b expected 11", bus.p1_dir); end
  endtask

  task automatic test_p2();
    send_byte(8'hE0);
    checks++; if (bus.scan_code !== 8'hE0) begin errs++; $display("FAIL p2_prefix_code: got %h expected e0", bus.scan_code); end
    checks++; if (bus.p2_dir !== 2'b11) begin errs++; $display("FAIL p2_prefix_nocmd: got %b expected 11", bus.p2_dir); end
    send_byte(8'h72);
    checks++; if (bus.p2_dir !== 2'b10) begin errs++; $display("FAIL p2_ext_down: got %b expected 10", bus.p2_dir); end
    send_byte(8'h74);
    checks++; if (bus.p2_dir !== 2'b10) begin errs++; $display("FAIL p2_keypad_ignored: got %b expected 10", bus.p2_dir); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    checks++; if (bus.p2_dir !== 2'b10) begin errs++; $display("FAIL p2_break_ignored: got %b expected 10", bus.p2_dir); end
    send_byte(8'h6B);
    checks++; if (bus.p2_dir !== 2'b10) begin errs++; $display("FAIL p2_ext_cleared: got %b expected 10", bus.p2_dir); end
    send_byte(8'hE0); send_byte(8'h74);
    checks++; if (bus.p2_dir !== 2'b01) begin errs++; $display("FAIL p2_brk_cleared: got %b expected 01", bus.p2_dir); end
    checks++; if (bus.p1_dir !== 2'b11) begin errs++; $display("FAIL p2_p1_untouched: got %b expected 11", bus.p1_dir); end
  endtask

  task automatic test_start_esc();
    int st0 = st_cnt, rr0 = rr_cnt;
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
    checks++; if (st_cnt - st0 !== 1) begin errs++; $display("FAIL start_typematic: got %0d expected 1", st_cnt - st0); end
    send_byte(8'hF0); send_byte(8'h29); send_byte(8'h29);
    checks++; if (st_cnt - st0 !== 2) begin errs++; $display("FAIL start_after_release: got %0d expected 2", st_cnt - st0); end
    send_byte(8'h76); send_byte(8'h76);
    checks++; if (rr_cnt - rr0 !== 2) begin errs++; $display("FAIL esc_repeat: got %0d expected 2", rr_cnt - rr0); end
    checks++; if (st_cnt - st0 !== 2) begin errs++; $display("FAIL esc_no_start: got %0d expected 2", st_cnt - st0); end
  endtask

  task automatic test_errors();
    int sv0, fe0;
    send_byte(8'h1D);
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(build_frame(8'h23, 1'b1, 1'b0), 11, 1'b0); bus.ps2_dat = 1'b1; wait_cyc(30);
    checks++; if (fe_cnt - fe0 !== 1) begin errs++; $display("FAIL parity_err: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (bus.scan_code !== 8'h1D) begin errs++; $display("FAIL parity_scan_code: got %h expected 1d", bus.scan_code); end
    checks++; if (bus.p1_dir !== 2'b00) begin errs++; $display("FAIL parity_p1_dir: got %b expected 00", bus.p1_dir); end
    checks++; if (sv_cnt !== sv0) begin errs++; $display("FAIL parity_no_valid: got %0d expected %0d", sv_cnt, sv0); end
    send_bits(build_frame(8'h23, 1'b0, 1'b1), 11, 1'b0); bus.ps2_dat = 1'b1; wait_cyc(30);
    checks++; if (fe_cnt - fe0 !== 2) begin errs++; $display("FAIL stop_err: got %0d expected 2", fe_cnt - fe0); end
    checks++; if (bus.p1_dir !== 2'b00) begin errs++; $display("FAIL stop_p1_dir: got %b expected 00", bus.p1_dir); end
    send_byte(8'h1C);
    send_bits(build_frame(8'h23, 1'b0, 1'b0), 6, 1'b0); bus.ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 100);
    checks++; if (fe_cnt - fe0 !== 3) begin errs++; $display("FAIL timeout_err: got %0d expected 3", fe_cnt - fe0); end
    checks++; if (bus.scan_code !== 8'h1C) begin errs++; $display("FAIL timeout_scan_code: got %h expected 1c", bus.scan_code); end
    send_byte(8'h1B);
    checks++; if (bus.scan_code !== 8'h1B) begin errs++; $display("FAIL after_timeout_code: got %h expected 1b", bus.scan_code); end
    checks++; if (bus.p1_dir !== 2'b10) begin errs++; $display("FAIL after_timeout_p1_dir: got %b expected 10", bus.p1_dir); end
  endtask

  task automatic test_glitch();
    int sv0 = sv_cnt, fe0 = fe_cnt;
    bus.ps2_dat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(15);
      bus.ps2_clk = 1'b0;
      wait_cyc(3);
      bus.ps2_clk = 1'b1;
    end
    wait_cyc(15);
    bus.ps2_dat = 1'b1;
    wait_cyc(20);
    checks++; if (sv_cnt !== sv0) begin errs++; $display("FAIL glitch_idle_valid: got %0d expected %0d", sv_cnt, sv0); end
    send_bits(build_frame(8'h23, 1'b0, 1'b0), 11, 1'b1); bus.ps2_dat = 1'b1; wait_cyc(30);
    checks++; if (bus.scan_code !== 8'h23) begin errs++; $display("FAIL glitch_scan_code: got %h expected 23", bus.scan_code); end
    checks++; if (bus.p1_dir !== 2'b01) begin errs++; $display("FAIL glitch_p1_dir: got %b expected 01", bus.p1_dir); end
    checks++; if (fe_cnt !== fe0) begin errs++; $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt, fe0); end
  endtask

  task automatic test_reset_mid();
    send_bits(build_frame(8'h1D, 1'b0, 1'b0), 5, 1'b0);
    pulse_reset();
    checks++; if (bus.p1_dir !== 2'b01) begin errs++; $display("FAIL midreset_p1_dir: got %b expected 01", bus.p1_dir); end
    checks++; if (bus.p2_dir !== 2'b11) begin errs++; $display("FAIL midreset_p2_dir: got %b expected 11", bus.p2_dir); end
    checks++; if (bus.scan_code !== 8'h00) begin errs++; $display("FAIL midreset_scan_code: got %h expected 00", bus.scan_code); end
    send_byte(8'h1D);
    checks++; if (bus.scan_code !== 8'h1D) begin errs++; $display("FAIL midreset_next_code: got %h expected 1d", bus.scan_code); end
    checks++; if (bus.p1_dir !== 2'b00) begin errs++; $display("FAIL midreset_next_p1: got %b expected 00", bus.p1_dir); end
  endtask

  task automatic test_back_to_back();
    int sv0 = sv_cnt;
    send_bits(build_frame(8'hE0, 1'b0, 1'b0), 11, 1'b0);
    send_bits(build_frame(8'h75, 1'b0, 1'b0), 11, 1'b0);
    bus.ps2_dat = 1'b1;
    wait_cyc(30);
    checks++; if (sv_cnt - sv0 !== 2) begin errs++; $display("FAIL b2b_valid_count: got %0d expected 2", sv_cnt - sv0); end
    checks++; if (bus.p2_dir !== 2'b00) begin errs++; $display("FAIL b2b_p2_dir: got %b expected 00", bus.p2_dir); end
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    reset = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    test_reset();
    test_basic();
    test_reverse();
    test_p2();
    test_start_esc();
    test_errors();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
